// File: rtl/cpu_defs.sv
// Shared definitions for the CPU front end: address width, reset/NOP defaults
// and the fetch FSM state encoding.
package cpu_defs;

    localparam int          CPU_ADDR_W   = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] CPU_NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} holding register behind the IF/ID slot. It catches a
// fetched word when decode stalls and hands it over on the next transfer.
module if_skid_buf
    import cpu_defs::*;
#(
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       instr_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       instr_o
);

    logic              full_q,  full_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [31:0]       instr_q, instr_d;

    // A flush beats everything; a load and a drain never coincide because a
    // load only happens while the slot is stalled.
    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (load_i) begin
            full_d  = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_if_stage.sv
// Program counter and instruction fetch: req/ack fetches gated by cpu_en,
// a valid/ready IF/ID register with a one-entry skid, and branch redirects.
module pc_if_stage #(
    parameter int                ADDR_W   = cpu_defs::CPU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_defs::CPU_RESET_PC,
    parameter logic [31:0]       NOP_WORD = cpu_defs::CPU_NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pc4,
    output logic [31:0]       if_instr
);

    import cpu_defs::*;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] ifPc_q, ifPc_d;
    logic [ADDR_W-1:0] ifPc4_q, ifPc4_d;
    logic [31:0]       ifInstr_q, ifInstr_d;

    logic              transfer, slotFree, ackTaken;
    logic              skidLoad, skidDrain, skidFull;
    logic [ADDR_W-1:0] skidPc, redirectAligned, pcPlus4;
    logic [31:0]       skidInstr;

    assign redirectAligned = redirect_pc & ~ADDR_W'(3);
    assign pcPlus4         = pc_q + PC_STEP;
    assign transfer        = valid_q & id_ready;
    assign slotFree        = ~valid_q | id_ready;
    assign ackTaken        = (state_q == WAIT) & imem_ack & ~redirect_valid;
    assign skidLoad        = ackTaken & ~slotFree;
    assign skidDrain       = transfer & skidFull & ~redirect_valid;

    if_skid_buf #(.ADDR_W(ADDR_W)) uSkid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skidLoad),
        .drain_i (skidDrain),
        .clear_i (redirect_valid),
        .pc_i    (addr_q),
        .instr_i (imem_rdata),
        .full_o  (skidFull),
        .pc_o    (skidPc),
        .instr_o (skidInstr)
    );

    // Fetch FSM. A redirect that lands while a fetch is in flight cannot
    // cancel the memory access, so DROP swallows the late ack instead.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirectAligned;
                end else if (cpu_en && !skidFull) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirectAligned;
                    if (imem_ack) begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    pc_d = pcPlus4;
                    if (cpu_en && !skidFull && !skidLoad) begin
                        addr_d = pcPlus4;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirectAligned;
                end
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // IF/ID slot: the skid refills it ahead of any fresh word so program
    // order is preserved across a decode stall.
    always_comb begin
        valid_d   = valid_q;
        ifPc_d    = ifPc_q;
        ifPc4_d   = ifPc4_q;
        ifInstr_d = ifInstr_q;
        if (redirect_valid) begin
            valid_d   = 1'b0;
            ifInstr_d = NOP_WORD;
        end else if (skidDrain) begin
            valid_d   = 1'b1;
            ifPc_d    = skidPc;
            ifPc4_d   = skidPc + PC_STEP;
            ifInstr_d = skidInstr;
        end else if (ackTaken && slotFree) begin
            valid_d   = 1'b1;
            ifPc_d    = addr_q;
            ifPc4_d   = addr_q + PC_STEP;
            ifInstr_d = imem_rdata;
        end else if (transfer) begin
            valid_d   = 1'b0;
            ifInstr_d = NOP_WORD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            valid_q   <= 1'b0;
            ifPc_q    <= '0;
            ifPc4_q   <= '0;
            ifInstr_q <= NOP_WORD;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            ifPc_q    <= ifPc_d;
            ifPc4_q   <= ifPc4_d;
            ifInstr_q <= ifInstr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = ifPc_q;
    assign if_pc4    = ifPc4_q;
    assign if_instr  = ifInstr_q;

endmodule

// File: tb/tb_pc_if_stage.sv
// Bench for pc_if_stage: a program-order fetch model checked every cycle,
// plus directed phases with hand-computed expectations.
module tb_pc_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        cpu_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;

    int   checks      = 0;
    int   errors      = 0;
    int   memLatency  = 0;
    logic strayAck    = 1'b0;
    int   reqStarts   = 0;

    pc_if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_en         (cpu_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .id_ready       (id_ready),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_instr       (if_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h0000_00A0 + {2'b00, a[31:2]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic ready, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        cpu_en         = en;
        id_ready       = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    task automatic doReset(input int lat, input logic enDuring);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        cpu_en         = enDuring;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        strayAck       = 1'b0;
        memLatency     = lat;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic waitValid(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, '0);
            @(negedge clk);
            if (if_valid) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    // Memory: acknowledges a held request after memLatency waiting cycles.
    initial begin
        int memCnt;
        memCnt     = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            imem_ack = 1'b0;
            if (!rst) begin
                memCnt = 0;
            end else if (strayAck) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end else if (imem_req) begin
                if (memCnt >= memLatency) begin
                    imem_ack   = 1'b1;
                    imem_rdata = memWord(imem_addr);
                    memCnt     = 0;
                end else begin
                    memCnt++;
                end
            end else begin
                memCnt = 0;
            end
        end
    end

    // Program-order model: decode must see consecutive words from the last
    // redirect target, each new request must follow a cpu_en strobe and name
    // the next unfetched address, and at most two words are ever held.
    initial begin
        logic [31:0] expPc, nextFetch, pAddr, pIfPc, pIfInstr;
        logic        pReq, pAck, pValid, pReady, pRedir, pCpuEn, dropping;
        int          held;
        expPc = '0; nextFetch = '0; pAddr = '0; pIfPc = '0; pIfInstr = '0;
        pReq = 0; pAck = 0; pValid = 0; pReady = 0; pRedir = 0; pCpuEn = 0; dropping = 0;
        held = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                expPc = '0; nextFetch = '0; held = 0; dropping = 0;
                pReq = 0; pAck = 0; pValid = 0; pReady = 0; pRedir = 0; pCpuEn = 0;
            end else begin
                checkOutput("valid_vs_model", 32'(if_valid), 32'(held != 0));
                if (!if_valid)
                    checkOutput("empty_instr", if_instr, NOP);
                else
                    checkOutput("pc4_rule", if_pc4, if_pc + 32'd4);
                if (pValid && !pReady && !pRedir) begin
                    checkOutput("frozen_pc", if_pc, pIfPc);
                    checkOutput("frozen_instr", if_instr, pIfInstr);
                end
                if (pReq && !pAck) begin
                    checkOutput("req_hold", 32'(imem_req), 32'd1);
                    checkOutput("addr_hold", imem_addr, pAddr);
                end
                if (imem_req && (!pReq || pAck)) begin
                    reqStarts++;
                    checkOutput("start_gate", 32'(pCpuEn), 32'd1);
                    checkOutput("start_addr", imem_addr, nextFetch);
                end
                if (if_valid && id_ready) begin
                    checkOutput("xfer_pc", if_pc, expPc);
                    checkOutput("xfer_instr", if_instr, memWord(expPc));
                    expPc = expPc + 32'd4;
                    held--;
                end
                if (imem_req && imem_ack) begin
                    if (redirect_valid || dropping) begin
                        dropping = 1'b0;
                    end else begin
                        nextFetch = imem_addr + 32'd4;
                        held++;
                    end
                end
                checkOutput("occupancy", 32'(held <= 2), 32'd1);
                if (redirect_valid) begin
                    nextFetch = redirect_pc & 32'hFFFF_FFFC;
                    expPc     = nextFetch;
                    held      = 0;
                    if (imem_req && !imem_ack) dropping = 1'b1;
                end
                pReq = imem_req; pAck = imem_ack; pAddr = imem_addr;
                pValid = if_valid; pReady = id_ready; pRedir = redirect_valid;
                pCpuEn = cpu_en; pIfPc = if_pc; pIfInstr = if_instr;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; cpu_en = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset and sequential fetch
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0);
        checkOutput("rst_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_instr", if_instr, NOP);
        checkOutput("rst_pc", if_pc, 32'h0);
        checkOutput("rst_pc4", if_pc4, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rel_req_low", 32'(imem_req), 32'd0);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("rel_req", 32'(imem_req), 32'd1);
        checkOutput("rel_addr", imem_addr, 32'h0);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("seq0_pc", if_pc, 32'h0);
        checkOutput("seq0_instr", if_instr, 32'hA0);
        checkOutput("seq0_pc4", if_pc4, 32'h4);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("seq1_pc", if_pc, 32'h4);
        checkOutput("seq1_instr", if_instr, 32'hA1);
        checkOutput("seq1_pc4", if_pc4, 32'h8);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("seq2_pc", if_pc, 32'h8);
        checkOutput("seq2_instr", if_instr, 32'hA2);
        checkOutput("seq2_pc4", if_pc4, 32'hC);

        // Decode stall fills the skid
        doReset(0, 1'b1);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 0, 0, '0);
        applyStimulus(1, 0, 0, '0); @(negedge clk);
        checkOutput("stall_req", 32'(imem_req), 32'd0);
        checkOutput("stall_pc", if_pc, 32'h0);
        checkOutput("stall_instr", if_instr, 32'hA0);
        applyStimulus(1, 0, 0, '0); @(negedge clk);
        checkOutput("stall_req2", 32'(imem_req), 32'd0);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("skid_pc", if_pc, 32'h4);
        checkOutput("skid_instr", if_instr, 32'hA1);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("resume_req", 32'(imem_req), 32'd1);
        checkOutput("resume_addr", imem_addr, 32'h8);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("resume_instr", if_instr, 32'hA2);

        // Redirect while waiting on a slow ack
        doReset(3, 1'b1);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 1, 1, 32'h103);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("drop_valid", 32'(if_valid), 32'd0);
        checkOutput("drop_req", 32'(imem_req), 32'd1);
        checkOutput("drop_addr", imem_addr, 32'h0);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("redir_addr", imem_addr, 32'h100);
        waitValid("redir_wait", 20);
        checkOutput("redir_pc", if_pc, 32'h100);
        checkOutput("redir_instr", if_instr, 32'hE0);

        // Redirect in the same cycle as the ack
        doReset(1, 1'b1);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(1, 1, 1, 32'h40);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("coin_req", 32'(imem_req), 32'd0);
        checkOutput("coin_valid", 32'(if_valid), 32'd0);
        applyStimulus(1, 1, 0, '0); @(negedge clk);
        checkOutput("coin_addr", imem_addr, 32'h40);
        waitValid("coin_wait", 20);
        checkOutput("coin_pc", if_pc, 32'h40);
        checkOutput("coin_instr", if_instr, 32'hB0);

        // cpu_en gating, stray ack in IDLE, and PC wrap
        doReset(0, 1'b0);
        applyStimulus(0, 1, 0, '0);
        strayAck = 1'b1;
        applyStimulus(0, 1, 0, '0);
        strayAck = 1'b0;
        @(negedge clk);
        checkOutput("stray_valid", 32'(if_valid), 32'd0);
        checkOutput("stray_req", 32'(imem_req), 32'd0);
        reqStarts = 0;
        for (int i = 0; i < 16; i++) applyStimulus(i % 4 == 0, 1, 0, '0);
        applyStimulus(0, 1, 0, '0); @(negedge clk);
        checkOutput("gate_starts", 32'(reqStarts), 32'd4);
        applyStimulus(0, 1, 1, 32'hFFFF_FFFC);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(0, 1, 0, '0); @(negedge clk);
        checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 0, '0); @(negedge clk);
        checkOutput("wrap_pc", if_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_instr", if_instr, 32'h4000_009F);
        checkOutput("wrap_pc4", if_pc4, 32'h0);
        applyStimulus(1, 1, 0, '0);
        applyStimulus(0, 1, 0, '0); @(negedge clk);
        checkOutput("wrap_next", imem_addr, 32'h0);
        checkOutput("wrap_next_req", 32'(imem_req), 32'd1);

        // Mixed traffic checked by the model alone
        doReset(0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            memLatency = $urandom_range(0, 2);
            applyStimulus($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 15) == 0, 32'($urandom_range(0, 255)));
        end
        repeat (8) applyStimulus(0, 1, 0, '0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
